led_arbiter: RTL and testbench
==============================

LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the LED.
REQ-002 Parameter SLOW_HALF, default 62_500_000, half-period in cycles of the slow blink (0.5 s at 125 MHz).
REQ-003 Parameter FAST_HALF, default 12_500_000, half-period in cycles of the fast blink (0.1 s).
REQ-004 Parameter SLOT_CYCLES, default 250_000_000, maximum grant length in cycles when other requesters are pending (2 s).
REQ-005 Parameter GAP_CYCLES, default 25_000_000, length in cycles of the LED-off gap between grants (gap build only).
REQ-006 clk_125mhz  input  1  system clock, 125 MHz from the PLL.
REQ-007 reset_n  input  1  reset, asynchronous, active-low.
REQ-008 req  input  N_REQ  per-requester display request, level-sensitive.
REQ-009 pattern  input  2*N_REQ  per-requester pattern code; bits [2i+1:2i] belong to requester i.
REQ-010 grant  output  N_REQ  one-hot current owner; all zero when nobody owns the LED.
REQ-011 led  output  1  LED drive, active-low (0 = lit).
REQ-012 busy  output  1  high while in GRANT or GAP.

Function
REQ-013 Pattern codes SHALL be: 00 OFF, 01 SOLID, 10 SLOW blink, 11 FAST blink.
REQ-014 FSM states SHALL be IDLE, GRANT, and GAP (gap build only).
REQ-015 In IDLE with any req high at edge t, the FSM SHALL enter GRANT at t+1; grant, led and busy SHALL be registered and update on that same edge.
REQ-016 Winner SHALL be the first requester with req high, searching round-robin from the rotation pointer; the pointer SHALL be set to winner+1 mod N_REQ on every grant.
REQ-017 The owner's pattern SHALL be latched at grant entry; pattern changes during a grant SHALL be ignored.
REQ-018 Blink phase SHALL start ON at grant entry and toggle after every HALF cycles (HALF = SLOW_HALF or FAST_HALF); OFF keeps the LED dark, SOLID keeps it lit.
REQ-019 The slot counter SHALL count cycles in GRANT; at SLOT_CYCLES, if another req is high, the grant SHALL release; otherwise the counter restarts and the grant holds.
REQ-020 If the owner's req drops, the grant SHALL release on the next edge.
REQ-021 If req drop and slot expiry coincide, this SHALL be treated as a req drop.
REQ-022 On release, the FSM SHALL go to GAP (gap build) or straight to arbitration; in the non-gap build a pending winner SHALL be granted on the release edge with no idle cycle.
REQ-023 Counter widths SHALL be $clog2 of their maximum value; no counter SHALL wrap past its terminal count.

Reset
REQ-024 Reset SHALL be asynchronous and active-low, clearing state to IDLE, pointer 0 and all counters to 0.
REQ-025 Outputs in reset SHALL be grant=0, busy=0, led=1 (dark).
REQ-026 Reset asserted mid-grant SHALL extinguish the LED immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro LED_ARB_GAP_EN defined: every release SHALL pass through GAP for GAP_CYCLES with grant=0, led=1 and busy=1, then re-arbitrate (or enter IDLE if no req is high).
REQ-028 Macro LED_ARB_GAP_EN undefined: GAP state, GAP_CYCLES logic and the gap counter SHALL be absent.

Structure
REQ-029 Package led_arb_pkg SHALL hold the pattern-code typedef/constants and the FSM state typedef.
REQ-030 Sub-module led_blink_gen SHALL hold the phase counter and the pattern decode (inputs: restart, pattern; output: on).

Verification (bench parameters: N_REQ=4, SLOW_HALF=8, FAST_HALF=2, SLOT_CYCLES=32, GAP_CYCLES=4)
REQ-031 req=0001, pattern0=SOLID at cycle 10 -> grant=0001 and led=0 from cycle 11; led holds 0 while req stays high.
REQ-032 req0 with FAST -> led runs 0,0,1,1,… starting at grant; with SLOW -> 8 cycles low, then 8 cycles high, repeating.
REQ-033 req=1001 both held -> grant alternates 0001/1000 every 32 cycles; with the gap build, 4 dark cycles with busy=1 between grants.
REQ-034 Owner req drops on the same cycle its slot expires, with req2 pending -> release, pointer=1, grant=0100 next (after the gap in the gap build).
REQ-035 reset_n pulsed low mid-grant -> led=1 and grant=0 asynchronously; after release with req=0010, grant=0010 (pointer restarted at 0).
REQ-036 Pattern changed mid-grant -> led sequence unchanged until the next grant.

Source files
------------

// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - pattern codes, FSM states and pattern decode for led_arbiter.
// The state set includes ST_GAP only when LED_ARB_GAP_EN is defined.
package led_arb_pkg;

  typedef enum logic [1:0] {
    PAT_OFF   = 2'b00,
    PAT_SOLID = 2'b01,
    PAT_SLOW  = 2'b10,
    PAT_FAST  = 2'b11
  } pattern_t;

`ifdef LED_ARB_GAP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;
`else
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;
`endif

  function automatic logic pattern_lit(pattern_t pat, logic phase);
    case (pat)
      PAT_OFF:   return 1'b0;
      PAT_SOLID: return 1'b1;
      default:   return phase;
    endcase
  endfunction

endpackage

// File: rtl/led_arbiter_if.sv
// rtl/led_arbiter_if.sv - request/pattern bus and LED ownership outputs of led_arbiter.
interface led_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] pattern;
  logic [N_REQ-1:0]   grant;
  logic               led;
  logic               busy;

  modport master (output req, pattern, input grant, led, busy);
  modport slave  (input req, pattern, output grant, led, busy);
endinterface

// File: rtl/led_blink_gen.sv
// rtl/led_blink_gen.sv - latches the owner's pattern and produces the registered lit flag.
module led_blink_gen
  import led_arb_pkg::*;
#(
  parameter int SLOW_HALF = 62_500_000,
  parameter int FAST_HALF = 12_500_000
) (
  input  logic     clk_125mhz,
  input  logic     reset_n,
  input  logic     restart,
  input  logic     enable,
  input  pattern_t pattern,
  output logic     on
);
  localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int CNT_W    = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

  pattern_t         pat_q;
  logic             phase;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             blinking;

  assign term     = (pat_q == PAT_FAST) ? CNT_W'(FAST_HALF - 1) : CNT_W'(SLOW_HALF - 1);
  assign blinking = (pat_q == PAT_SLOW) || (pat_q == PAT_FAST);

  // `on` is computed one step ahead so it is valid on the same edge the grant starts.
  always_ff @(posedge clk_125mhz or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= PAT_OFF;
      phase <= 1'b0;
      cnt   <= '0;
      on    <= 1'b0;
    end else if (restart) begin
      pat_q <= pattern;
      phase <= 1'b1;
      cnt   <= '0;
      on    <= pattern_lit(pattern, 1'b1);
    end else if (!enable) begin
      phase <= 1'b0;
      cnt   <= '0;
      on    <= 1'b0;
    end else if (blinking) begin
      if (cnt == term) begin
        cnt   <= '0;
        phase <= ~phase;
        on    <= pattern_lit(pat_q, ~phase);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - round-robin owner arbitration of one active-low status LED.
// Define LED_ARB_GAP_EN to insert a dark GAP_CYCLES gap between grants.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SLOW_HALF   = 62_500_000,
  parameter int FAST_HALF   = 12_500_000,
  parameter int SLOT_CYCLES = 250_000_000,
  parameter int GAP_CYCLES  = 25_000_000
) (
  input logic         clk_125mhz,
  input logic         reset_n,
  led_arbiter_if.slave bus
);
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  ptr_next;
  logic [N_REQ-1:0]  grant_q;
  logic              busy_q;
  logic [SLOT_W-1:0] slot_cnt;
  logic              slot_done;
  logic              found;
  logic              drop_grant;
  logic              take_grant;
  logic              blink_on;
  pattern_t          win_pattern;

`ifdef LED_ARB_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_done;
  assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
`endif

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req[(int'(ptr) + k) % N_REQ]) begin
        found   = 1'b1;
        win_idx = PTR_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign ptr_next    = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign win_pattern = pattern_t'(bus.pattern[2*int'(win_idx) +: 2]);
  assign slot_done   = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
  // A dropped owner request always releases, even when the slot also expires.
  assign drop_grant  = (state == ST_GRANT) &&
                       (!bus.req[owner] || (slot_done && |(bus.req & ~grant_q)));

  always_comb begin
    take_grant = 1'b0;
    case (state)
      ST_IDLE:  take_grant = found;
`ifdef LED_ARB_GAP_EN
      ST_GAP:   take_grant = found && gap_done;
`else
      ST_GRANT: take_grant = found && drop_grant;
`endif
      default:  take_grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk_125mhz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      slot_cnt <= '0;
`ifdef LED_ARB_GAP_EN
      gap_cnt  <= '0;
`endif
    end else if (take_grant) begin
      state    <= ST_GRANT;
      owner    <= win_idx;
      ptr      <= ptr_next;
      grant_q  <= N_REQ'(1) << win_idx;
      busy_q   <= 1'b1;
      slot_cnt <= '0;
`ifdef LED_ARB_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_GRANT: begin
          if (drop_grant) begin
            grant_q  <= '0;
            slot_cnt <= '0;
`ifdef LED_ARB_GAP_EN
            state    <= ST_GAP;
`else
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
`endif
          end else begin
            slot_cnt <= slot_done ? '0 : slot_cnt + 1'b1;
          end
        end
`ifdef LED_ARB_GAP_EN
        ST_GAP: begin
          if (gap_done) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  led_blink_gen #(
    .SLOW_HALF (SLOW_HALF),
    .FAST_HALF (FAST_HALF)
  ) u_blink (
    .clk_125mhz (clk_125mhz),
    .reset_n    (reset_n),
    .restart    (take_grant),
    .enable     ((state == ST_GRANT) && !drop_grant),
    .pattern    (win_pattern),
    .on         (blink_on)
  );

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.led   = ~blink_on;

endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - scoreboard bench for led_arbiter against a cycle-count reference model.
// Follows LED_ARB_GAP_EN so the model matches whichever build is compiled.
module tb_led_arbiter;
  localparam int N    = 4;
  localparam int SLOW = 8;
  localparam int FAST = 2;
  localparam int SLOT = 32;
`ifdef LED_ARB_GAP_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif

  logic clk_125mhz = 1'b0;
  logic reset_n    = 1'b0;

  led_arbiter_if #(.N_REQ(N)) bus ();

  led_arbiter #(
    .N_REQ       (N),
    .SLOW_HALF   (SLOW),
    .FAST_HALF   (FAST),
    .SLOT_CYCLES (SLOT),
    .GAP_CYCLES  (4)
  ) dut (
    .clk_125mhz (clk_125mhz),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  always #5 clk_125mhz = ~clk_125mhz;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic       led;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner index (-1 = none), rotation pointer, gap cycles left,
  // cycles held so far, cycles since grant start and the latched pattern.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_gap   = 0;
  int         m_age   = 0;
  int         m_t     = 0;
  logic [1:0] m_pat   = 2'b00;

  always @(posedge clk_125mhz) cyc++;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req_val);
    checks++;
    if (act !== req_val) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, act, req_val);
    end
  endtask

  function automatic logic model_lit();
    case (m_pat)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return ((m_t / SLOW) % 2) == 0;
      default: return ((m_t / FAST) % 2) == 0;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_gap   = 0;
    m_age   = 0;
    m_t     = 0;
  endtask

  task automatic model_arb(input logic [3:0] r, input logic [7:0] p);
    m_gap = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r[i]) begin
        m_owner = i;
        m_ptr   = (i + 1) % N;
        m_age   = 1;
        m_t     = 0;
        m_pat   = p[2*i +: 2];
        return;
      end
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic [7:0] p);
    if (m_owner >= 0) begin
      if (!r[m_owner] || ((m_age % SLOT) == 0 && (r & ~(4'b0001 << m_owner)) != 4'b0000)) begin
        m_owner = -1;
        if (GAP > 0) m_gap = GAP;
        else model_arb(r, p);
      end else begin
        m_age++;
        m_t++;
      end
    end else if (m_gap > 0) begin
      if (m_gap == 1) model_arb(r, p);
      else m_gap--;
    end else begin
      model_arb(r, p);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [7:0] p, input int n);
    for (int j = 0; j < n; j++) begin
      exp_t e;
      bus.req     = r;
      bus.pattern = p;
      model_step(r, p);
      e.cyc   = cyc + 1;
      e.grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e.led   = (m_owner >= 0) ? !model_lit() : 1'b1;
      e.busy  = (m_owner >= 0) || (m_gap > 0);
      sb.push_back(e);
      @(posedge clk_125mhz);
      #1;
    end
  endtask

  // Asserts reset between edges and checks that outputs go dark without a clock.
  task automatic pulse_reset();
    @(negedge clk_125mhz);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_grant", bus.grant, 4'b0000);
    check("async_rst_led", {3'b000, bus.led}, 4'b0001);
    check("async_rst_busy", {3'b000, bus.busy}, 4'b0000);
    sb.delete();
    model_reset();
    bus.req = 4'b0000;
    @(posedge clk_125mhz);
    @(posedge clk_125mhz);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_125mhz);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL sb_order cycle %0d: entry for cycle %0d left unchecked", cyc, e.cyc);
        end else begin
          check("grant", bus.grant, e.grant);
          check("led", {3'b000, bus.led}, {3'b000, e.led});
          check("busy", {3'b000, bus.busy}, {3'b000, e.busy});
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] r;
    logic [7:0] p;
    bus.req     = 4'b0000;
    bus.pattern = 8'h00;
    repeat (3) @(posedge clk_125mhz);
    #1;
    check("reset_grant", bus.grant, 4'b0000);
    check("reset_led", {3'b000, bus.led}, 4'b0001);
    check("reset_busy", {3'b000, bus.busy}, 4'b0000);
    reset_n = 1'b1;
    model_reset();

    // Solid, fast and slow patterns on requester 0.
    drive(4'b0000, 8'h00, 5);
    drive(4'b0001, 8'h01, 20);
    drive(4'b0000, 8'h00, 2);
    drive(4'b0001, 8'h03, 12);
    drive(4'b0000, 8'h00, 1);
    drive(4'b0001, 8'h02, 40);
    drive(4'b0000, 8'h00, 1);

    // Pattern edited mid-grant must not affect the running sequence.
    drive(4'b0001, 8'h02, 5);
    drive(4'b0001, 8'h03, 20);
    drive(4'b0000, 8'h00, GAP + 2);

    // Two persistent requesters share the LED slot by slot.
    drive(4'b1001, 8'hC1, 140);
    drive(4'b0000, 8'h00, GAP + 2);

    // Owner drops exactly when its slot expires, requester 2 pending.
    pulse_reset();
    drive(4'b0001, 8'h31, 1);
    drive(4'b0101, 8'h31, 31);
    drive(4'b0100, 8'h31, 12);

    // Reset mid-grant restarts the pointer at 0.
    pulse_reset();
    drive(4'b1100, 8'hA0, 6);
    drive(4'b0000, 8'h00, GAP + 2);
    drive(4'b0010, 8'h04, 8);
    drive(4'b0000, 8'h00, GAP + 2);

    r = 4'b0000;
    p = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 3) == 0) p = 8'($urandom);
      drive(r, p, 1);
    end

    @(negedge clk_125mhz);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
